sqrt_mem_arbiter: RTL and testbench
===================================

Name: sqrt_mem_arbiter

Overview:
- Shares one sqrt_mem read port between N_REQ independent requesters, e.g. parallel classifier stages that need sqrt lookups for variance normalisation.
- Arbitrates address requests round-robin and forwards the winner to the memory address channel.
- Records the winner's index in an in-order tag FIFO, then steers each returned data word to the requester that issued it.
- Sits between the stage datapaths and sqrt_mem; all channels use valid/ready.

Parameters:
- N_REQ, 2, number of requesters; 2..8.
- W_DATA, 16, sqrt data width.
- W_ADDR, 8, sqrt table address width.
- MAX_OUTST, 4, maximum outstanding (issued, not yet returned) reads; tag FIFO depth; power of 2, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester address valid
- req_ready  out  N_REQ  per-requester address accepted
- req_addr  in  N_REQ*W_ADDR  packed addresses; requester i at bits [i*W_ADDR +: W_ADDR]
- rsp_valid  out  N_REQ  per-requester data valid; one-hot or zero
- rsp_ready  in  N_REQ  per-requester data ready
- rsp_data  out  W_DATA  shared data bus, broadcast to all requesters
- mem_addr_valid  out  1  to sqrt_mem addr1_valid
- mem_addr_ready  in  1  from sqrt_mem addr1_ready
- mem_addr_data  out  W_ADDR  to sqrt_mem addr1_data
- mem_data_valid  in  1  from sqrt_mem data1_valid
- mem_data_ready  out  1  to sqrt_mem data1_ready
- mem_data  in  W_DATA  from sqrt_mem data1
- err  out  1  sticky protocol error flag

Behaviour:
- Reset, asynchronous: round-robin pointer ptr=0, tag FIFO empty (count 0), err=0.
  - Outputs therefore come up as req_ready=0, rsp_valid=0, mem_addr_valid=0, mem_data_ready=0.
- Grant (combinational): the first i with req_valid[i]=1, searching ptr, ptr+1, ... mod N_REQ. g is the granted index.
- Issue path, zero-cycle combinational:
  - mem_addr_valid = any(req_valid) && !full.
  - mem_addr_data = req_addr[g].
  - req_ready[g] = mem_addr_ready && !full; every other req_ready bit is 0.
- Issue handshake (mem_addr_valid && mem_addr_ready): push g into the tag FIFO; ptr <= (g+1) mod N_REQ.
  - ptr is unchanged when there is no handshake, so the grant is stable while the valid set is stable.
- Requesters hold req_valid and req_addr stable until req_ready. The arbiter does not lock a grant across cycles.
- Response path, zero-cycle combinational: with t = FIFO head tag and the FIFO non-empty:
  - rsp_valid[t] = mem_data_valid.
  - mem_data_ready = rsp_ready[t].
  - rsp_data = mem_data at all times.
- Response handshake (mem_data_valid && mem_data_ready): pop the tag FIFO. Responses are returned strictly in issue order.
- Full (count = MAX_OUTST): issue is blocked even if a pop occurs in the same cycle; no bypass.
- Simultaneous push and pop when not full: count is unchanged; pointers advance.
- Empty FIFO with mem_data_valid=1: this is a protocol violation.
  - mem_data_ready=0 and all rsp_valid=0.
  - err <= 1, held until reset.
- A single requester may have several reads outstanding. Back-to-back issue at 1 per cycle is required when mem_addr_ready=1 and the FIFO is not full.
- Reset mid-operation drops all outstanding tags. sqrt_mem shares rst, so no stale data arrives afterwards.

Optional Feature:
- Macro SQRT_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority; the lowest index with req_valid wins, ptr is removed, and starvation is permitted.
  - Undefined (default): round-robin as above.
- All other behaviour is identical.

Test Plan:
- Single requester, N_REQ=2: req0 issues 0x10, 0x11, 0x12 back-to-back with mem_addr_ready=1 -> 3 issues in 3 cycles; rsp_valid[0] returns sqrt(0x10..0x12) in order; rsp_valid[1] never asserts.
- Contention: req0 and req1 both continuously valid -> grants alternate 0,1,0,1 starting at 0 after reset; each response is routed to the matching requester.
  - With SQRT_ARB_FIXED_PRIO_EN defined: all grants go to 0 until req0 drops.
- Full: MAX_OUTST=4, mem_data_ready path stalled by rsp_ready=0 -> exactly 4 issues, then mem_addr_valid=0 and req_ready=0.
  - Releasing rsp_ready for one cycle pops 1; issue resumes the next cycle, not the same cycle.
- Response backpressure: tag head=1 with rsp_ready[1]=0 -> mem_data_ready=0 and data held; rsp_ready[0]=1 has no effect.
- Protocol error: mem_data_valid=1 forced while the FIFO is empty -> err=1 next cycle, rsp_valid=0, err stays 1 until rst.
- Reset mid-flight: assert rst with 3 tags outstanding -> all outputs drop immediately to reset values; count=0 and ptr=0 after release.

Source files
------------

// File: rtl/sqrt_mem_arbiter.sv
// Round-robin arbiter sharing one sqrt_mem read port between N_REQ requesters; an in-order
// tag FIFO steers each returned word back to its issuer. Define SQRT_ARB_FIXED_PRIO_EN for fixed priority.
module sqrt_mem_arbiter #(
    parameter int N_REQ     = 2,
    parameter int W_DATA    = 16,
    parameter int W_ADDR    = 8,
    parameter int MAX_OUTST = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*W_ADDR-1:0] req_addr,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [W_DATA-1:0]       rsp_data,
    output logic                    mem_addr_valid,
    input  logic                    mem_addr_ready,
    output logic [W_ADDR-1:0]       mem_addr_data,
    input  logic                    mem_data_valid,
    output logic                    mem_data_ready,
    input  logic [W_DATA-1:0]       mem_data,
    output logic                    err
);

    localparam int W_TAG = $clog2(N_REQ);
    localparam int W_PTR = $clog2(MAX_OUTST);
    localparam int W_CNT = W_PTR + 1;
    localparam logic [W_CNT-1:0] FULL_CNT = W_CNT'(MAX_OUTST);
    localparam logic [W_TAG-1:0] LAST_REQ = W_TAG'(N_REQ - 1);

    logic                any_valid_s;
    logic                full_s;
    logic                empty_s;
    logic                push_s;
    logic                pop_s;
    logic                mem_addr_valid_s;
    logic                mem_data_ready_s;
    logic [W_TAG-1:0]    grant_s;
    logic [W_TAG-1:0]    head_tag_s;
    logic [N_REQ-1:0]    req_ready_s;
    logic [N_REQ-1:0]    rsp_valid_s;
    logic [W_ADDR-1:0]   addr_arr_s [N_REQ];

    logic [W_TAG-1:0]    tag_mem_q [MAX_OUTST];
    logic [W_TAG-1:0]    tag_mem_d [MAX_OUTST];
    logic [W_PTR-1:0]    wr_ptr_q;
    logic [W_PTR-1:0]    wr_ptr_d;
    logic [W_PTR-1:0]    rd_ptr_q;
    logic [W_PTR-1:0]    rd_ptr_d;
    logic [W_CNT-1:0]    count_q;
    logic [W_CNT-1:0]    count_d;
    logic                err_q;
    logic                err_d;

    function automatic logic [W_TAG-1:0] next_idx(input logic [W_TAG-1:0] idx);
        if (idx == LAST_REQ) begin
            return {W_TAG{1'b0}};
        end else begin
            return idx + 1'b1;
        end
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_addr_unpack
            assign addr_arr_s[gi] = req_addr[gi*W_ADDR +: W_ADDR];
        end
    endgenerate

`ifdef SQRT_ARB_FIXED_PRIO_EN
    // Grant: lowest-index valid requester wins; descending scan leaves the lowest.
    always_comb begin
        logic [W_TAG-1:0] idx_v;
        idx_v   = {W_TAG{1'b0}};
        grant_s = {W_TAG{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_v = W_TAG'(k);
            if (req_valid[idx_v]) begin
                grant_s = idx_v;
            end else begin
                grant_s = grant_s;
            end
        end
    end
`else
    logic [W_TAG-1:0] ptr_q;
    logic [W_TAG-1:0] ptr_d;

    // Grant: first valid requester at or after ptr; descending offset scan leaves the nearest.
    always_comb begin
        logic [W_TAG-1:0] idx_v;
        idx_v   = {W_TAG{1'b0}};
        grant_s = {W_TAG{1'b0}};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx_v = W_TAG'((int'(ptr_q) + k) % N_REQ);
            if (req_valid[idx_v]) begin
                grant_s = idx_v;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    // Round-robin pointer moves past the winner only on an accepted issue.
    always_comb begin
        if (push_s) begin
            ptr_d = next_idx(grant_s);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= {W_TAG{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Issue path: full blocks issue even when a pop happens in the same cycle.
    always_comb begin
        any_valid_s      = |req_valid;
        full_s           = (count_q == FULL_CNT);
        mem_addr_valid_s = any_valid_s && !full_s && !rst;
        push_s           = mem_addr_valid_s && mem_addr_ready;
        req_ready_s      = {N_REQ{1'b0}};
        if (push_s) begin
            req_ready_s[grant_s] = 1'b1;
        end else begin
            req_ready_s = {N_REQ{1'b0}};
        end
    end

    // Response path: steer data to the FIFO head tag; data with no tag outstanding is an error.
    always_comb begin
        empty_s          = (count_q == {W_CNT{1'b0}});
        head_tag_s       = tag_mem_q[rd_ptr_q];
        rsp_valid_s      = {N_REQ{1'b0}};
        mem_data_ready_s = 1'b0;
        if (!empty_s) begin
            rsp_valid_s[head_tag_s] = mem_data_valid;
            mem_data_ready_s        = rsp_ready[head_tag_s];
        end else begin
            rsp_valid_s      = {N_REQ{1'b0}};
            mem_data_ready_s = 1'b0;
        end
        pop_s = mem_data_valid && mem_data_ready_s;
        err_d = err_q || (empty_s && mem_data_valid);
    end

    // Tag FIFO next state.
    always_comb begin
        tag_mem_d = tag_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_s) begin
            tag_mem_d[wr_ptr_q] = grant_s;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Tag FIFO and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                tag_mem_q[i] <= {W_TAG{1'b0}};
            end
            wr_ptr_q <= {W_PTR{1'b0}};
            rd_ptr_q <= {W_PTR{1'b0}};
            count_q  <= {W_CNT{1'b0}};
            err_q    <= 1'b0;
        end else begin
            tag_mem_q <= tag_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_q     <= err_d;
        end
    end

    assign req_ready      = req_ready_s;
    assign mem_addr_valid = mem_addr_valid_s;
    assign mem_addr_data  = addr_arr_s[grant_s];
    assign rsp_valid      = rsp_valid_s;
    assign mem_data_ready = mem_data_ready_s;
    assign rsp_data       = mem_data;
    assign err            = err_q;

endmodule

// File: tb/tb_sqrt_mem_arbiter.sv
// Self-checking bench for sqrt_mem_arbiter: queue-based arbiter model plus a sqrt_mem responder.
module tb_sqrt_mem_arbiter;

    localparam int N_REQ     = 2;
    localparam int W_DATA    = 16;
    localparam int W_ADDR    = 8;
    localparam int MAX_OUTST = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*W_ADDR-1:0] req_addr;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ-1:0]        rsp_ready;
    logic [W_DATA-1:0]       rsp_data;
    logic                    mem_addr_valid;
    logic                    mem_addr_ready;
    logic [W_ADDR-1:0]       mem_addr_data;
    logic                    mem_data_valid;
    logic                    mem_data_ready;
    logic [W_DATA-1:0]       mem_data;
    logic                    err;

    sqrt_mem_arbiter #(.N_REQ(N_REQ), .W_DATA(W_DATA), .W_ADDR(W_ADDR), .MAX_OUTST(MAX_OUTST)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mem_addr_valid(mem_addr_valid), .mem_addr_ready(mem_addr_ready), .mem_addr_data(mem_addr_data),
        .mem_data_valid(mem_data_valid), .mem_data_ready(mem_data_ready), .mem_data(mem_data),
        .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // model state: rr pointer, outstanding requester ids, pending memory addresses, sticky error
    int         ptr_m;
    int         tags_m[$];
    logic [7:0] memq[$];
    bit         err_m;
    // requester address queues, observation logs
    logic [7:0]  rq0[$];
    logic [7:0]  rq1[$];
    int          issue_log[$];
    logic [15:0] rx0[$];
    logic [15:0] rx1[$];
    // stimulus knobs
    bit         mar_k;
    bit         mem_en_k;
    bit         mem_force_k;
    logic [1:0] rr_k;
    int         exp_seq[6];

    // sqrt_mem content: 8.8 fixed-point floor(sqrt(addr))
    function automatic logic [15:0] sq(input logic [7:0] a);
        int v;
        int r;
        v = int'(a) * 256;
        r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return 16'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        req_valid      = {rq1.size() > 0, rq0.size() > 0};
        req_addr       = {(rq1.size() > 0) ? rq1[0] : 8'h00, (rq0.size() > 0) ? rq0[0] : 8'h00};
        mem_addr_ready = mar_k;
        rsp_ready      = rr_k;
        mem_data_valid = mem_force_k || (mem_en_k && memq.size() > 0);
        mem_data       = (memq.size() > 0) ? sq(memq[0]) : 16'hBEEF;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ptr_m = 0;
        tags_m.delete();
        memq.delete();
        err_m = 1'b0;
        rq0.delete();
        rq1.delete();
        mar_k = 1'b0;
        rr_k = 2'b00;
        mem_en_k = 1'b0;
        mem_force_k = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        issue_log.delete();
        rx0.delete();
        rx1.delete();
    endtask

    // compare DUT against the model every cycle, then advance the model
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            int g;
            int c;
            int t;
            bit any;
            bit full;
            bit empty;
            logic e_mav;
            logic e_mdr;
            logic [7:0] e_addr;
            logic [1:0] e_rr;
            logic [1:0] e_rv;
            any   = (req_valid != 2'b00);
            full  = (tags_m.size() == MAX_OUTST);
            empty = (tags_m.size() == 0);
            g = 0;
`ifdef SQRT_ARB_FIXED_PRIO_EN
            for (int k = 0; k < N_REQ; k++) begin
                if (req_valid[k]) begin
                    g = k;
                    break;
                end
            end
`else
            for (int k = 0; k < N_REQ; k++) begin
                c = (ptr_m + k) % N_REQ;
                if (req_valid[c]) begin
                    g = c;
                    break;
                end
            end
`endif
            e_mav  = any && !full;
            e_addr = (g == 0) ? req_addr[7:0] : req_addr[15:8];
            e_rr   = (e_mav && mem_addr_ready) ? (2'b01 << g) : 2'b00;
            t      = empty ? 0 : tags_m[0];
            e_rv   = (!empty && mem_data_valid) ? (2'b01 << t) : 2'b00;
            e_mdr  = !empty && rsp_ready[t];
            chk("mem_addr_valid", mem_addr_valid, e_mav);
            if (e_mav) chk("mem_addr_data", mem_addr_data, e_addr);
            chk("req_ready", req_ready, e_rr);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("mem_data_ready", mem_data_ready, e_mdr);
            chk("rsp_data", rsp_data, mem_data);
            chk("err", err, err_m);
            if (!empty && mem_data_valid && e_mdr) begin
                if (t == 0) rx0.push_back(rsp_data);
                else rx1.push_back(rsp_data);
                void'(tags_m.pop_front());
                void'(memq.pop_front());
            end
            if (e_mav && mem_addr_ready) begin
                tags_m.push_back(g);
                memq.push_back(e_addr);
                ptr_m = (g + 1) % N_REQ;
                issue_log.push_back(g);
                if (g == 0) void'(rq0.pop_front());
                else void'(rq1.pop_front());
            end
            if (empty && mem_data_valid) err_m = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        rst = 1'b1;
        mar_k = 1'b0;
        rr_k = 2'b00;
        mem_en_k = 1'b0;
        mem_force_k = 1'b0;
        drive();
        #2;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_mem_addr_valid", mem_addr_valid, 1'b0);
        chk("rst_mem_data_ready", mem_data_ready, 1'b0);
        chk("rst_err", err, 1'b0);

        // single requester, back-to-back issue then in-order returns
        do_reset();
        rq0.push_back(8'h10); rq0.push_back(8'h11); rq0.push_back(8'h12);
        mar_k = 1'b1; rr_k = 2'b11;
        repeat (3) tick();
        settle();
        chk("t1_issue_cnt", issue_log.size(), 3);
        chk("t1_issue_req", issue_log[0] | issue_log[1] | issue_log[2], 0);
        mem_en_k = 1'b1;
        repeat (6) tick();
        settle();
        chk("t1_rx0_cnt", rx0.size(), 3);
        chk("t1_rx0_0", rx0[0], 16'd64);
        chk("t1_rx0_1", rx0[1], 16'd65);
        chk("t1_rx0_2", rx0[2], 16'd67);
        chk("t1_rx1_cnt", rx1.size(), 0);

        // contention from reset
        do_reset();
        rq0.push_back(8'h20); rq0.push_back(8'h21); rq0.push_back(8'h22);
        rq1.push_back(8'h30); rq1.push_back(8'h31); rq1.push_back(8'h32);
        mar_k = 1'b1; rr_k = 2'b11; mem_en_k = 1'b1;
        repeat (14) tick();
        settle();
`ifdef SQRT_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
        chk("t2_issue_cnt", issue_log.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_grant%0d", i), issue_log[i], exp_seq[i]);
        chk("t2_rx0_0", rx0[0], 16'd90);
        chk("t2_rx0_1", rx0[1], 16'd91);
        chk("t2_rx0_2", rx0[2], 16'd93);
        chk("t2_rx1_0", rx1[0], 16'd110);
        chk("t2_rx1_1", rx1[1], 16'd112);
        chk("t2_rx1_2", rx1[2], 16'd113);

        // full FIFO, one pop, issue resumes next cycle
        do_reset();
        for (int i = 0; i < 6; i++) rq0.push_back(8'(8'h40 + i));
        mar_k = 1'b1; mem_en_k = 1'b1; rr_k = 2'b00;
        repeat (8) tick();
        settle();
        chk("t3_full_issue_cnt", issue_log.size(), 4);
        chk("t3_full_mav", mem_addr_valid, 1'b0);
        rr_k = 2'b01;
        tick();
        settle();
        chk("t3_pop_no_bypass", issue_log.size(), 4);
        chk("t3_pop_rx0_cnt", rx0.size(), 1);
        chk("t3_pop_rx0_0", rx0[0], 16'd128);
        rr_k = 2'b00;
        tick();
        settle();
        chk("t3_resume_issue_cnt", issue_log.size(), 5);

        // head tag 1 stalled while requester 0 is ready
        do_reset();
        mar_k = 1'b1; mem_en_k = 1'b1; rr_k = 2'b01;
        rq1.push_back(8'h50);
        tick();
        rq0.push_back(8'h51);
        repeat (4) tick();
        settle();
        chk("t4_issue_cnt", issue_log.size(), 2);
        chk("t4_first_tag", issue_log[0], 1);
        chk("t4_stall_rx0", rx0.size(), 0);
        chk("t4_stall_rx1", rx1.size(), 0);
        chk("t4_stall_mdr", mem_data_ready, 1'b0);
        rr_k = 2'b11;
        repeat (3) tick();
        settle();
        chk("t4_rx1_0", rx1[0], 16'd143);
        chk("t4_rx0_0", rx0[0], 16'd144);

        // data with nothing outstanding
        do_reset();
        mem_force_k = 1'b1;
        tick();
        mem_force_k = 1'b0;
        repeat (3) tick();
        settle();
        chk("t5_err_sticky", err, 1'b1);
        do_reset();
        chk("t5_err_cleared", err, 1'b0);

        // reset with three tags outstanding
        do_reset();
        for (int i = 0; i < 5; i++) rq0.push_back(8'(8'h60 + i));
        mar_k = 1'b1; rr_k = 2'b00;
        repeat (3) tick();
        settle();
        chk("t6_outstanding", issue_log.size(), 3);
        mem_en_k = 1'b1;
        drive();
        rst = 1'b1;
        #1;
        chk("t6_rst_mav", mem_addr_valid, 1'b0);
        chk("t6_rst_req_ready", req_ready, 2'b00);
        chk("t6_rst_rsp_valid", rsp_valid, 2'b00);
        chk("t6_rst_mdr", mem_data_ready, 1'b0);
        chk("t6_rst_err", err, 1'b0);
        do_reset();
        rq0.push_back(8'h70); rq0.push_back(8'h71); rq0.push_back(8'h72);
        rq1.push_back(8'h80); rq1.push_back(8'h81); rq1.push_back(8'h82);
        mar_k = 1'b1; rr_k = 2'b00;
        repeat (6) tick();
        settle();
        chk("t6_post_issue_cnt", issue_log.size(), 4);
`ifdef SQRT_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 1, 0, 0};
`else
        exp_seq = '{0, 1, 0, 1, 0, 0};
`endif
        for (int i = 0; i < 4; i++) chk($sformatf("t6_grant%0d", i), issue_log[i], exp_seq[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
